// File: rtl/ring_delay_sched_pkg.sv
// Shared types and helpers for the ring-oscillator stage delay scheduler.
// Holds the FSM state type, default widths and the modular long-window test.
package ring_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_t;

  localparam int N_DEF   = 16;
  localparam int LOG2_2N = $clog2(2 * N_DEF);
  localparam int K_W     = $clog2(N_DEF) + 1;

  // Stage j is long when it lies in the K-wide window starting at ptr (mod n).
  function automatic logic stage_is_long(
    input int j,
    input int ptr,
    input int k,
    input int n
  );
    return ((j - ptr) & (n - 1)) < k;
  endfunction

endpackage

// File: rtl/ring_delay_sched_if.sv
// Control/data bundle between the DCO period logic and the delay scheduler.
// master drives the period request and ticks; slave returns stage delays.
interface ring_delay_sched_if #(
  parameter int N_STAGES = 16,
  parameter int PERIOD_W = 32,
  parameter int DELAY_W  = 32
);

  logic                          en;
  logic [PERIOD_W-1:0]           period_fs;
  logic                          period_ld;
  logic                          tick;
  logic [N_STAGES*DELAY_W-1:0]   delay_fs;
  logic [$clog2(N_STAGES):0]     long_cnt;
  logic                          upd;
  logic                          range_err;

  modport master (
    output en, period_fs, period_ld, tick,
    input  delay_fs, long_cnt, upd, range_err
  );

  modport slave (
    input  en, period_fs, period_ld, tick,
    output delay_fs, long_cnt, upd, range_err
  );

endinterface

// File: rtl/ring_delay_sched_dither_acc.sv
// First-order carry accumulator and rotation pointer for the long-stage window.
// K long stages per tick; the odd half-step is carried into the next tick.
module ring_dither_acc
  import ring_pkg::*;
#(
  parameter int N_STAGES  = N_DEF,
  parameter bit DITHER_EN = 1'b1,
  parameter int REM_W     = LOG2_2N,
  parameter int KW        = K_W,
  parameter int PW        = $clog2(N_STAGES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear_i,
  input  logic             restart_i,
  input  logic             tick_i,
  input  logic [REM_W-1:0] rem_i,
  output logic [KW-1:0]    k_o,
  output logic [PW-1:0]    ptr_o
);

  logic          carry_q;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [REM_W:0] acc;

  always_comb begin
    acc   = {1'b0, rem_i} + (REM_W + 1)'(carry_q);
    k_o   = KW'(acc[REM_W:1]);
    ptr_d = ptr_q + k_o[PW-1:0];
  end

  assign ptr_o = ptr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      carry_q <= 1'b0;
      ptr_q   <= '0;
    end else if (clear_i) begin
      carry_q <= 1'b0;
      ptr_q   <= '0;
    end else if (restart_i) begin
      carry_q <= 1'b0;
    end else if (tick_i && DITHER_EN) begin
      carry_q <= acc[0];
      ptr_q   <= ptr_d;
    end
  end

endmodule

// File: rtl/ring_delay_sched.sv
// Splits a requested DCO period into per-inverter delays with dithered
// remainder and rotating long-stage window.
module ring_delay_sched
  import ring_pkg::*;
#(
  parameter int N_STAGES     = N_DEF,
  parameter int PERIOD_W     = 32,
  parameter int DELAY_W      = 32,
  parameter bit DITHER_EN    = 1'b1,
  parameter int RST_DELAY_FS = 12500
) (
  input  logic              clk,
  input  logic              rst,
  ring_delay_sched_if.slave bus
);

  localparam int LG = $clog2(2 * N_STAGES);
  localparam int KW = $clog2(N_STAGES) + 1;
  localparam int PW = $clog2(N_STAGES);
  localparam logic [DELAY_W-1:0]  RST_D = DELAY_W'(RST_DELAY_FS);
  localparam logic [PERIOD_W-1:0] MIN_P = PERIOD_W'(2 * N_STAGES);

  state_t state_q, state_d;
  logic [PERIOD_W-1:0] samp_q;
  logic [PERIOD_W-1:0] shifted;
  logic [DELAY_W-1:0]  base_q, base_d, base_p1;
  logic [LG-1:0]       rem_q, rem_d;
  logic                range_q, range_now;
  logic [N_STAGES-1:0][DELAY_W-1:0] dly_q, dly_d;
  logic [KW-1:0]       cnt_q, k;
  logic [PW-1:0]       ptr;
  logic                upd_q;
  logic                ld_ok, tick_run, clr;

  assign ld_ok    = bus.en && bus.period_ld && (state_q != LOAD);
  assign tick_run = bus.en && bus.tick && !bus.period_ld
                    && (state_q == RUN);
  assign clr      = (state_q == IDLE) || !bus.en;

  always_comb begin
    state_d = state_q;
    if (!bus.en) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (bus.period_ld) state_d = LOAD;
        LOAD:    state_d = RUN;
        RUN:     if (bus.period_ld) state_d = LOAD;
        default: state_d = IDLE;
      endcase
    end
  end

  // Too-short periods collapse to one fs per stage, no remainder.
  always_comb begin
    shifted   = samp_q >> LG;
    range_now = samp_q < MIN_P;
    base_d    = range_now ? DELAY_W'(1) : DELAY_W'(shifted);
    rem_d     = range_now ? '0 : samp_q[LG-1:0];
  end

  ring_dither_acc #(
    .N_STAGES  (N_STAGES),
    .DITHER_EN (DITHER_EN),
    .REM_W     (LG),
    .KW        (KW),
    .PW        (PW)
  ) u_acc (
    .clk       (clk),
    .rst       (rst),
    .clear_i   (clr),
    .restart_i (state_q == LOAD),
    .tick_i    (tick_run),
    .rem_i     (rem_q),
    .k_o       (k),
    .ptr_o     (ptr)
  );

  always_comb begin
    base_p1 = (&base_q) ? base_q : base_q + DELAY_W'(1);
    for (int j = 0; j < N_STAGES; j++) begin
      dly_d[j] = stage_is_long(j, int'(ptr), int'(k), N_STAGES)
                 ? base_p1 : base_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      samp_q  <= '0;
      base_q  <= '0;
      rem_q   <= '0;
      range_q <= 1'b0;
      dly_q   <= {N_STAGES{RST_D}};
      cnt_q   <= '0;
      upd_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      upd_q   <= tick_run;
      if (ld_ok) samp_q <= bus.period_fs;
      if (state_q == LOAD) begin
        base_q  <= base_d;
        rem_q   <= rem_d;
        range_q <= range_q | range_now;
      end
      if (tick_run) begin
        dly_q <= dly_d;
        cnt_q <= k;
      end
    end
  end

  assign bus.delay_fs  = dly_q;
  assign bus.long_cnt  = cnt_q;
  assign bus.upd       = upd_q;
  assign bus.range_err = range_q;

endmodule

// File: tb/tb_ring_delay_sched.sv
// Directed bench for ring_delay_sched: dithered and static instances
// driven in parallel, hand-computed delay patterns per tick.
module tb_ring_delay_sched;

  logic        clk;
  logic        rst;
  logic        en;
  logic        ld;
  logic        tick;
  logic [31:0] pfs;
  int          errors;
  int          checks;

  ring_delay_sched_if #(.N_STAGES(16), .PERIOD_W(32), .DELAY_W(32)) b0 ();
  ring_delay_sched_if #(.N_STAGES(16), .PERIOD_W(32), .DELAY_W(32)) b1 ();

  assign b0.en = en;
  assign b0.period_ld = ld;
  assign b0.tick = tick;
  assign b0.period_fs = pfs;
  assign b1.en = en;
  assign b1.period_ld = ld;
  assign b1.tick = tick;
  assign b1.period_fs = pfs;

  ring_delay_sched #(.DITHER_EN(1'b1)) u_dith (
    .clk (clk),
    .rst (rst),
    .bus (b0.slave)
  );

  ring_delay_sched #(.DITHER_EN(1'b0)) u_stat (
    .clk (clk),
    .rst (rst),
    .bus (b1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [511:0] expv(input int base, input logic [15:0] m);
    logic [511:0] v;
    v = '0;
    for (int j = 0; j < 16; j++) v[j*32 +: 32] = 32'(base) + 32'(m[j]);
    return v;
  endfunction

  task automatic load(input logic [31:0] p);
    pfs = p;
    ld = 1'b1;
    @(posedge clk); #1;
    ld = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic pulse_tick();
    tick = 1'b1;
    @(posedge clk); #1;
    tick = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; ld = 1'b0; tick = 1'b0; pfs = '0;
    @(posedge clk); #1;
    checks++;
    if (b0.delay_fs !== expv(12500, 16'h0000)) begin
      errors++; $display("FAIL rst_dly got=%h exp=%h", b0.delay_fs, expv(12500, 16'h0000));
    end
    checks++;
    if (b0.long_cnt !== 5'd0) begin
      errors++; $display("FAIL rst_cnt got=%0d exp=0", b0.long_cnt);
    end
    checks++;
    if (b0.upd !== 1'b0 || b0.range_err !== 1'b0) begin
      errors++; $display("FAIL rst_flags upd=%b rerr=%b exp=0,0", b0.upd, b0.range_err);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_nominal();
    load(32'd400000);
    for (int i = 0; i < 3; i++) begin
      pulse_tick();
      checks++;
      if (b0.upd !== 1'b1) begin
        errors++; $display("FAIL nom_upd%0d got=%b exp=1", i, b0.upd);
      end
      checks++;
      if (b0.delay_fs !== expv(12500, 16'h0000)) begin
        errors++; $display("FAIL nom_dly%0d got=%h exp=%h", i, b0.delay_fs, expv(12500, 16'h0000));
      end
      checks++;
      if (b0.long_cnt !== 5'd0) begin
        errors++; $display("FAIL nom_cnt%0d got=%0d exp=0", i, b0.long_cnt);
      end
    end
    checks++;
    if (b0.range_err !== 1'b0) begin
      errors++; $display("FAIL nom_rerr got=%b exp=0", b0.range_err);
    end
    @(posedge clk); #1;
    checks++;
    if (b0.upd !== 1'b0) begin
      errors++; $display("FAIL nom_upd_low got=%b exp=0", b0.upd);
    end
  endtask

  task automatic test_dither();
    logic [15:0] masks [4];
    int          ks [4];
    longint      tot;
    masks = '{16'h00FF, 16'hFF01, 16'h01FE, 16'hFE03};
    ks = '{8, 9, 8, 9};
    tot = 0;
    load(32'd400017);
    for (int i = 0; i < 4; i++) begin
      pulse_tick();
      checks++;
      if (b0.upd !== 1'b1 || b0.delay_fs !== expv(12500, masks[i])) begin
        errors++; $display("FAIL dith_dly%0d upd=%b got=%h exp=%h", i, b0.upd, b0.delay_fs, expv(12500, masks[i]));
      end
      checks++;
      if (b0.long_cnt !== 5'(ks[i])) begin
        errors++; $display("FAIL dith_cnt%0d got=%0d exp=%0d", i, b0.long_cnt, ks[i]);
      end
      checks++;
      if (b1.delay_fs !== expv(12500, 16'h00FF) || b1.long_cnt !== 5'd8) begin
        errors++; $display("FAIL stat_dly%0d cnt=%0d got=%h exp=%h", i, b1.long_cnt, b1.delay_fs, expv(12500, 16'h00FF));
      end
      if (i < 2) begin
        for (int j = 0; j < 16; j++) tot += 2 * longint'(b0.delay_fs[j*32 +: 32]);
      end
      if (i == 1) begin
        checks++;
        if (tot !== 64'd800034) begin
          errors++; $display("FAIL dith_avg got=%0d exp=800034", tot);
        end
      end
    end
  endtask

  task automatic test_full();
    logic [15:0] masks [3];
    int          ks [3];
    masks = '{16'hFFFD, 16'hFFFF, 16'hFFFE};
    ks = '{15, 16, 15};
    load(32'd400031);
    for (int i = 0; i < 3; i++) begin
      pulse_tick();
      checks++;
      if (b0.delay_fs !== expv(12500, masks[i])) begin
        errors++; $display("FAIL full_dly%0d got=%h exp=%h", i, b0.delay_fs, expv(12500, masks[i]));
      end
      checks++;
      if (b0.long_cnt !== 5'(ks[i])) begin
        errors++; $display("FAIL full_cnt%0d got=%0d exp=%0d", i, b0.long_cnt, ks[i]);
      end
    end
  endtask

  task automatic test_range();
    load(32'd20);
    checks++;
    if (b0.range_err !== 1'b1) begin
      errors++; $display("FAIL rng_set got=%b exp=1", b0.range_err);
    end
    pulse_tick();
    checks++;
    if (b0.delay_fs !== expv(1, 16'h0000) || b0.long_cnt !== 5'd0) begin
      errors++; $display("FAIL rng_dly cnt=%0d got=%h exp=%h", b0.long_cnt, b0.delay_fs, expv(1, 16'h0000));
    end
    load(32'd400000);
    pulse_tick();
    checks++;
    if (b0.range_err !== 1'b1) begin
      errors++; $display("FAIL rng_sticky got=%b exp=1", b0.range_err);
    end
    checks++;
    if (b0.delay_fs !== expv(12500, 16'h0000)) begin
      errors++; $display("FAIL rng_recover got=%h exp=%h", b0.delay_fs, expv(12500, 16'h0000));
    end
  endtask

  task automatic test_collision();
    load(32'd400017);
    pulse_tick();
    checks++;
    if (b0.delay_fs !== expv(12500, 16'h00FF)) begin
      errors++; $display("FAIL col_pre got=%h exp=%h", b0.delay_fs, expv(12500, 16'h00FF));
    end
    pfs = 32'd400031;
    ld = 1'b1;
    tick = 1'b1;
    @(posedge clk); #1;
    ld = 1'b0;
    tick = 1'b0;
    checks++;
    if (b0.upd !== 1'b0) begin
      errors++; $display("FAIL col_upd got=%b exp=0", b0.upd);
    end
    @(posedge clk); #1;
    checks++;
    if (b0.upd !== 1'b0 || b0.delay_fs !== expv(12500, 16'h00FF)) begin
      errors++; $display("FAIL col_hold upd=%b got=%h exp=%h", b0.upd, b0.delay_fs, expv(12500, 16'h00FF));
    end
    pulse_tick();
    checks++;
    if (b0.upd !== 1'b1 || b0.delay_fs !== expv(12500, 16'hFF7F)) begin
      errors++; $display("FAIL col_new upd=%b got=%h exp=%h", b0.upd, b0.delay_fs, expv(12500, 16'hFF7F));
    end
    checks++;
    if (b0.long_cnt !== 5'd15) begin
      errors++; $display("FAIL col_cnt got=%0d exp=15", b0.long_cnt);
    end
  endtask

  task automatic test_rst_mid();
    #2 rst = 1'b1;
    #2;
    checks++;
    if (b0.delay_fs !== expv(12500, 16'h0000)) begin
      errors++; $display("FAIL mid_dly got=%h exp=%h", b0.delay_fs, expv(12500, 16'h0000));
    end
    checks++;
    if (b0.long_cnt !== 5'd0 || b0.range_err !== 1'b0 || b0.upd !== 1'b0) begin
      errors++; $display("FAIL mid_flags cnt=%0d rerr=%b upd=%b exp=0,0,0", b0.long_cnt, b0.range_err, b0.upd);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 2; i++) begin
      pulse_tick();
      checks++;
      if (b0.upd !== 1'b0 || b0.delay_fs !== expv(12500, 16'h0000)) begin
        errors++; $display("FAIL mid_idle%0d upd=%b got=%h", i, b0.upd, b0.delay_fs);
      end
    end
    en = 1'b0;
    load(32'd400031);
    en = 1'b1;
    pulse_tick();
    checks++;
    if (b0.upd !== 1'b0) begin
      errors++; $display("FAIL en_off_ld upd=%b exp=0", b0.upd);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_nominal();
    test_dither();
    test_full();
    test_range();
    test_collision();
    test_rst_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
